// File: rtl/nn_mac_array.sv
// -----------------------------------------------------------------------------
// nn_mac_array
//
// Multi-lane fixed-point multiply-accumulate engine. One shared activation
// s_x per input beat is multiplied by LANES weights. The products are summed
// per lane until a beat with s_last closes the vector. Each lane sum then
// gets its bias added, is rounded (round-half-up) and saturated, and has ReLU
// applied when relu_en is set. The result leaves on a valid/ready port.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   s_valid/s_ready/s_last input beat handshake; s_ready is registered
//   s_x                    shared activation, signed Q(DWIDTH-FRAC).FRAC
//   s_w                    weights, lane i = s_w[i*DWIDTH +: DWIDTH]
//   s_bias, relu_en        per-lane bias and ReLU enable, taken on the s_last beat
//   m_valid/m_ready        result handshake
//   m_data                 per-lane results, same packing as s_w
//   m_ovf                  per-lane saturation flags
//   m_count                beats in the vector (saturating)
//   busy                   high whenever the engine is not accepting beats
// -----------------------------------------------------------------------------
module nn_mac_array #(
    parameter int LANES  = 4,
    parameter int DWIDTH = 16,
    parameter int FRAC   = 8,
    parameter int AWIDTH = 40,
    parameter int CWIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    input  logic [DWIDTH-1:0]       s_x,
    input  logic [LANES*DWIDTH-1:0] s_w,
    input  logic [LANES*DWIDTH-1:0] s_bias,
    input  logic                    relu_en,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LANES*DWIDTH-1:0] m_data,
    output logic [LANES-1:0]        m_ovf,
    output logic [CWIDTH-1:0]       m_count,
    output logic                    busy
);

    localparam int PWIDTH = 2 * DWIDTH;

    // Saturation bounds and the rounding constant, all at accumulator width.
    localparam logic signed [AWIDTH-1:0] SAT_MAX =
        {{(AWIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH-1:0] SAT_MIN =
        {{(AWIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
    localparam logic signed [AWIDTH-1:0] RND =
        {{(AWIDTH-1){1'b0}}, 1'b1} << (FRAC-1);

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        FIN   = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic s_hs;
    logic m_hs;

    logic signed [PWIDTH-1:0] prod_d [LANES];
    logic signed [PWIDTH-1:0] prod_q [LANES];
    logic                     prod_vld_q;
    logic signed [AWIDTH-1:0] acc_q  [LANES];
    logic [CWIDTH-1:0]        cnt_q;
    logic [LANES*DWIDTH-1:0]  bias_q;
    logic                     relu_q;

    logic [LANES*DWIDTH-1:0]  res_d;
    logic [LANES-1:0]         ovf_d;

    assign s_hs = s_valid & s_ready;
    assign m_hs = m_valid & m_ready;
    assign busy = (state_q != ACC);

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for state_d.
        state_d = state_q;
        case (state_q)
            ACC:     if (s_hs && s_last) state_d = DRAIN;
            DRAIN:   state_d = FIN;
            FIN:     state_d = OUT;
            OUT:     if (m_hs) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // s_ready and m_valid are registered copies of the next state, so s_ready
    // drops on the same edge that accepts the s_last beat and rises on the
    // first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= ACC;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            s_ready <= (state_d == ACC);
            m_valid <= (state_d == OUT);
        end
    end

    // -------------------------------------------------------------------------
    // Per-lane product and result arithmetic
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [DWIDTH-1:0] bias_i;
        logic signed [AWIDTH-1:0] sum;
        logic signed [AWIDTH-1:0] shifted;
        logic signed [DWIDTH-1:0] sat;
        logic                     clip;

        // Size casts of signed operands sign-extend, giving the full product.
        assign prod_d[i] = PWIDTH'($signed(s_x)) * PWIDTH'($signed(s_w[i*DWIDTH +: DWIDTH]));

        // Bias is aligned to the accumulator's 2*FRAC fractional bits; adding
        // half an LSB before the arithmetic shift rounds half toward +inf.
        assign bias_i  = bias_q[i*DWIDTH +: DWIDTH];
        assign sum     = acc_q[i] + (AWIDTH'(bias_i) <<< FRAC) + RND;
        assign shifted = sum >>> FRAC;

        always_comb begin
            clip = 1'b0;
            sat  = shifted[DWIDTH-1:0];
            if (shifted > SAT_MAX) begin
                sat  = SAT_MAX[DWIDTH-1:0];
                clip = 1'b1;
            end else if (shifted < SAT_MIN) begin
                sat  = SAT_MIN[DWIDTH-1:0];
                clip = 1'b1;
            end
            // ReLU acts after saturation and leaves the overflow flag alone.
            if (relu_q && sat[DWIDTH-1]) begin
                sat = '0;
            end
        end

        assign res_d[i*DWIDTH +: DWIDTH] = sat;
        assign ovf_d[i]                  = clip;
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: products and accumulators are small per-lane flop arrays,
            // not RAM, so they are reset so that a vector cut short by reset
            // leaves no partial sum behind.
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
                acc_q[i]  <= '0;
            end
            prod_vld_q <= 1'b0;
            cnt_q      <= '0;
            bias_q     <= '0;
            relu_q     <= 1'b0;
            m_data     <= '0;
            m_ovf      <= '0;
            m_count    <= '0;
        end else begin
            prod_vld_q <= s_hs;
            for (int i = 0; i < LANES; i++) begin
                if (s_hs) begin
                    prod_q[i] <= prod_d[i];
                end
                // Accumulate one edge behind the product register; this is
                // what the DRAIN state waits for after the last beat.
                if (m_hs) begin
                    acc_q[i] <= '0;
                end else if (prod_vld_q) begin
                    acc_q[i] <= acc_q[i] + AWIDTH'(prod_q[i]);
                end
            end

            if (m_hs) begin
                cnt_q <= '0;
            end else if (s_hs && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (s_hs && s_last) begin
                bias_q <= s_bias;
                relu_q <= relu_en;
            end

            if (state_q == FIN) begin
                m_data  <= res_d;
                m_ovf   <= ovf_d;
                m_count <= cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_nn_mac_array.sv
// -----------------------------------------------------------------------------
// tb_nn_mac_array
//
// Scoreboard bench for nn_mac_array (LANES=4, DWIDTH=16, FRAC=8). Each vector
// pushes its expected result, computed from a real-valued reference, when it
// is driven; results are popped and compared when the DUT presents them.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_nn_mac_array;

    localparam int LANES  = 4;
    localparam int DW     = 16;
    localparam int FRAC   = 8;
    localparam int AW     = 40;
    localparam int CW     = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               s_valid;
    logic               s_ready;
    logic               s_last;
    logic [DW-1:0]      s_x;
    logic [LANES*DW-1:0] s_w;
    logic [LANES*DW-1:0] s_bias;
    logic               relu_en;
    logic               m_valid;
    logic               m_ready;
    logic [LANES*DW-1:0] m_data;
    logic [LANES-1:0]   m_ovf;
    logic [CW-1:0]      m_count;
    logic               busy;

    always #5 clk = ~clk;

    nn_mac_array #(
        .LANES (LANES),
        .DWIDTH(DW),
        .FRAC  (FRAC),
        .AWIDTH(AW),
        .CWIDTH(CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_last (s_last),
        .s_x    (s_x),
        .s_w    (s_w),
        .s_bias (s_bias),
        .relu_en(relu_en),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_ovf  (m_ovf),
        .m_count(m_count),
        .busy   (busy)
    );

    typedef struct packed {
        logic [LANES*DW-1:0] data;
        logic [LANES-1:0]    ovf;
        logic [CW-1:0]       cnt;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Beat stimulus for the vector currently being sent.
    int bx [64];
    int bw [64][LANES];

    // Reference: exact integer sum of products, then scaled and rounded in
    // real arithmetic (floor(v + 0.5)), then clipped and ReLU'd.
    function automatic res_t model(input int n, input int bias[LANES], input bit relu);
        res_t   r;
        longint acc;
        longint q;
        real    v;
        real    scale;
        r     = '0;
        scale = 2.0 ** FRAC;
        for (int l = 0; l < LANES; l++) begin
            acc = 0;
            for (int b = 0; b < n; b++) begin
                acc += longint'(bx[b]) * longint'(bw[b][l]);
            end
            v = $floor((real'(acc) + real'(bias[l]) * scale) / scale + 0.5);
            q = longint'(v);
            if (q > 32767) begin
                q = 32767;
                r.ovf[l] = 1'b1;
            end else if (q < -32768) begin
                q = -32768;
                r.ovf[l] = 1'b1;
            end
            if (relu && q < 0) q = 0;
            r.data[l*DW +: DW] = q[DW-1:0];
        end
        r.cnt = CW'(n);
        return r;
    endfunction

    // Drive n beats from bx/bw; s_last on the final beat only if last_flag.
    // Starts and ends on a falling edge.
    task automatic send_beats(input int n, input bit last_flag,
                              input int bias[LANES], input bit relu);
        int guard;
        for (int b = 0; b < n; b++) begin
            guard = 0;
            while (s_ready !== 1'b1 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (s_ready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL s_ready_timeout beat %0d: s_ready=%b required 1", b, s_ready);
                s_valid = 1'b0;
                return;
            end
            s_valid = 1'b1;
            s_last  = last_flag && (b == n - 1);
            s_x     = bx[b][DW-1:0];
            for (int l = 0; l < LANES; l++) begin
                s_w[l*DW +: DW]    = bw[b][l][DW-1:0];
                s_bias[l*DW +: DW] = bias[l][DW-1:0];
            end
            relu_en = relu;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_vector(input int n, input int bias[LANES], input bit relu);
        exp_q.push_back(model(n, bias, relu));
        send_beats(n, 1'b1, bias, relu);
    endtask

    // Wait (bounded) for m_valid, capture the result, then accept it.
    task automatic get_result(output res_t got, output bit ok);
        int guard;
        guard = 0;
        ok    = 1'b0;
        got   = '0;
        while (m_valid !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (m_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: m_valid=%b required 1", m_valid);
            return;
        end
        got     = {m_data, m_ovf, m_count};
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        ok      = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_data, m_ovf, m_count, busy} !== '0) begin
            errors++;
            $display("FAIL reset_values: s_ready=%b m_valid=%b m_data=%h m_ovf=%h m_count=%0d busy=%b required all 0",
                     s_ready, m_valid, m_data, m_ovf, m_count, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_reset: s_ready=%b busy=%b required 1/0", s_ready, busy);
        end
    endtask

    task automatic test_basic();
        res_t got, expv;
        bit   ok;
        for (int b = 0; b < 3; b++) begin
            bx[b] = 256;
            bw[b] = '{256, 512, -256, 0};
        end
        send_vector(3, '{0, 0, 0, 0}, 1'b0);
        // Now just after edge k (the s_last handshake).
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_k: m_valid=%b s_ready=%b busy=%b required 0/0/1", m_valid, s_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_k1: m_valid=%b required 0", m_valid);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_k2: m_valid=%b required 1", m_valid);
        end
        checks++;
        if (m_data !== 64'h0000_FD00_0600_0300 || m_count !== 16'd3 || m_ovf !== 4'h0) begin
            errors++;
            $display("FAIL basic_literal: m_data=%h m_ovf=%h m_count=%0d required 0000fd0006000300/0/3",
                     m_data, m_ovf, m_count);
        end
        get_result(got, ok);
        expv = exp_q.pop_front();
        if (ok) begin
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL basic_result: got %h required %h", got, expv);
            end
        end
    endtask

    task automatic test_saturation();
        res_t got, expv;
        bit   ok;
        int   wv[2] = '{32767, -32767};
        for (int t = 0; t < 2; t++) begin
            for (int b = 0; b < 4; b++) begin
                bx[b] = 32767;
                bw[b] = '{wv[t], wv[t], wv[t], wv[t]};
            end
            send_vector(4, '{0, 0, 0, 0}, 1'b0);
            get_result(got, ok);
            expv = exp_q.pop_front();
            if (ok) begin
                checks++;
                if (got !== expv) begin
                    errors++;
                    $display("FAIL saturation_%0d: got %h required %h", t, got, expv);
                end
                if (t == 0) begin
                    checks++;
                    if (got.data !== {4{16'h7FFF}} || got.ovf !== 4'hF) begin
                        errors++;
                        $display("FAIL saturation_literal: data=%h ovf=%h required 7fff x4 / f", got.data, got.ovf);
                    end
                end
            end
        end
    endtask

    task automatic test_bias_relu();
        res_t got, expv;
        bit   ok;
        bx[0] = -256;
        bw[0] = '{256, 256, 256, 256};
        for (int r = 0; r < 2; r++) begin
            send_vector(1, '{64, 64, 64, 64}, r[0]);
            get_result(got, ok);
            expv = exp_q.pop_front();
            if (ok) begin
                checks++;
                if (got !== expv) begin
                    errors++;
                    $display("FAIL bias_relu_%0d: got %h required %h", r, got, expv);
                end
                checks++;
                if (got.data[15:0] !== ((r == 0) ? 16'hFF40 : 16'h0000) || got.ovf !== 4'h0) begin
                    errors++;
                    $display("FAIL bias_relu_lane0_%0d: lane0=%h ovf=%h", r, got.data[15:0], got.ovf);
                end
            end
        end
    endtask

    task automatic test_rounding();
        res_t got, expv;
        bit   ok;
        int   xs[3] = '{1, 1, -1};
        int   ws[3] = '{128, 127, 128};
        for (int t = 0; t < 3; t++) begin
            bx[0] = xs[t];
            bw[0] = '{ws[t], ws[t], ws[t], ws[t]};
            send_vector(1, '{0, 0, 0, 0}, 1'b0);
            get_result(got, ok);
            expv = exp_q.pop_front();
            if (ok) begin
                checks++;
                if (got !== expv) begin
                    errors++;
                    $display("FAIL rounding_%0d: got %h required %h", t, got, expv);
                end
            end
        end
    endtask

    task automatic test_stall();
        res_t got, expv, snap;
        bit   ok;
        int   guard;
        bx[0] = 300;  bw[0] = '{100, -200, 300, -400};
        bx[1] = -77;  bw[1] = '{999, 5, -1234, 42};
        send_vector(2, '{10, -10, 20, -20}, 1'b0);
        guard = 0;
        while (m_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        snap = exp_q[0];
        for (int c = 0; c < 10; c++) begin
            s_valid = c[0];
            s_last  = 1'b1;
            s_x     = DW'($urandom);
            @(negedge clk);
            checks++;
            if ({m_data, m_ovf, m_count} !== snap || s_ready !== 1'b0 || m_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold_%0d: out=%h s_ready=%b m_valid=%b required %h/0/1",
                         c, {m_data, m_ovf, m_count}, s_ready, m_valid, snap);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        get_result(got, ok);
        expv = exp_q.pop_front();
        if (ok) begin
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL stall_result: got %h required %h", got, expv);
            end
        end
        for (int b = 0; b < 3; b++) begin
            bx[b] = 64 * (b + 1);
            bw[b] = '{256, -128, 77, 1000};
        end
        send_vector(3, '{0, 5, 0, -5}, 1'b0);
        get_result(got, ok);
        expv = exp_q.pop_front();
        if (ok) begin
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL stall_next: got %h required %h", got, expv);
            end
        end
    endtask

    task automatic test_reset_mid();
        res_t got, expv;
        bit   ok;
        for (int b = 0; b < 5; b++) begin
            bx[b] = 500;
            bw[b] = '{700, 700, 700, 700};
        end
        send_beats(2, 1'b0, '{0, 0, 0, 0}, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_data, m_ovf, m_count, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_values: s_ready=%b m_valid=%b m_count=%0d busy=%b required all 0",
                     s_ready, m_valid, m_count, busy);
        end
        rst_n = 1'b1;
        bx[0] = 256;
        bw[0] = '{256, 256, 256, 256};
        send_vector(1, '{0, 0, 0, 0}, 1'b0);
        get_result(got, ok);
        expv = exp_q.pop_front();
        if (ok) begin
            checks++;
            if (got !== expv || got.data !== {4{16'h0100}} || got.cnt !== 16'd1) begin
                errors++;
                $display("FAIL reset_mid_result: got %h required %h", got, expv);
            end
        end
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        fork
            begin : sender
                int nb;
                int bias_r[LANES];
                for (int v = 0; v < 3; v++) begin
                    nb = int'($urandom_range(5, 1));
                    for (int b = 0; b < nb; b++) begin
                        bx[b] = int'($urandom_range(4000)) - 2000;
                        for (int l = 0; l < LANES; l++) bw[b][l] = int'($urandom_range(4000)) - 2000;
                    end
                    for (int l = 0; l < LANES; l++) bias_r[l] = int'($urandom_range(1000)) - 500;
                    send_vector(nb, bias_r, (v == 1));
                end
            end
            begin : collector
                int   guard;
                res_t expv;
                for (int r = 0; r < 3; r++) begin
                    guard = 0;
                    while (m_valid !== 1'b1 && guard < 100) begin
                        @(negedge clk);
                        guard++;
                    end
                    checks++;
                    if (m_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_timeout_%0d: m_valid=%b required 1", r, m_valid);
                    end else begin
                        expv = exp_q.pop_front();
                        if ({m_data, m_ovf, m_count} !== expv) begin
                            errors++;
                            $display("FAIL b2b_result_%0d: got %h required %h", r, {m_data, m_ovf, m_count}, expv);
                        end
                    end
                    @(negedge clk);
                end
            end
        join
        m_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    initial begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_x     = '0;
        s_w     = '0;
        s_bias  = '0;
        relu_en = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;

        test_reset();
        test_basic();
        test_saturation();
        test_bias_relu();
        test_rounding();
        test_stall();
        test_reset_mid();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
